// File: rtl/oh_cdc_txarb.sv
// oh_cdc_txarb: round-robin arbiter feeding a toggle-handshake CDC transmitter.
module oh_cdc_txarb #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int TW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         req_ready,
  output logic                 cdc_req,
  output logic [DW-1:0]        cdc_data,
  output logic [$clog2(N)-1:0] cdc_src,
  input  logic                 ack_sync,
  input  logic [TW-1:0]        timeout_cfg,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int SW = $clog2(N);
  typedef enum logic [1:0] {INIT, IDLE, WAIT} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_last, w_win;
  logic [TW-1:0] r_cnt;
  logic r_fired, w_any, w_match, w_accept, w_to;
  function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] last, input int k);
    return SW'((int'(last) + k) % N);
  endfunction
  // descending scan so the smallest offset past the last grant wins
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = N; k >= 1; k--)
      if (req_valid[rr_idx(r_last, k)]) begin
        w_any = 1'b1;
        w_win = rr_idx(r_last, k);
      end
  end
  assign w_match  = ack_sync == cdc_req;
  assign w_accept = r_state == IDLE && w_match && w_any && !reset;
  assign w_to     = r_state == WAIT && !w_match && timeout_cfg != '0 &&
                    r_cnt == timeout_cfg - TW'(1) && !r_fired;
  always_comb begin
    w_next    = r_state;
    w_next    = !w_match ? (r_state == IDLE ? INIT : r_state) : (w_accept ? WAIT : IDLE);
    req_ready = w_accept ? N'(1) << w_win : '0;
    busy      = reset || r_state != IDLE;
  end
  always_ff @(posedge clk)
    r_state <= reset ? INIT : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      cdc_req     <= 1'b0;
      cdc_data    <= '0;
      cdc_src     <= '0;
      r_last      <= SW'(N - 1);
      r_cnt       <= '0;
      r_fired     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= w_to;
      if (w_accept) begin
        cdc_req  <= ~cdc_req;
        cdc_data <= req_data[w_win*DW +: DW];
        cdc_src  <= w_win;
        r_last   <= w_win;
        r_cnt    <= '0;
        r_fired  <= 1'b0;
      end else if (r_state == WAIT) begin
        if (!(&r_cnt)) r_cnt <= r_cnt + TW'(1);
        if (w_to) r_fired <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_oh_cdc_txarb.sv
// tb_oh_cdc_txarb: directed and randomized checks of oh_cdc_txarb against a transaction-level model.
module tb_oh_cdc_txarb;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         cdc_req;
  logic [31:0]  cdc_data;
  logic [1:0]   cdc_src;
  logic         ack_sync;
  logic [7:0]   timeout_cfg;
  logic         busy, timeout_err;
  logic [31:0]  dat [4];
  int checks = 0, errors = 0;
  int m_mode, m_last, m_wc, m_src, am;
  logic m_req, m_fired, m_err, last_busy, last_err;
  logic [31:0] m_data;
  logic [3:0] last_ready;
  logic hist [8];

  always #5 clk = ~clk;
  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  oh_cdc_txarb #(.N(4), .DW(32), .TW(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cdc_req(cdc_req), .cdc_data(cdc_data), .cdc_src(cdc_src),
    .ack_sync(ack_sync), .timeout_cfg(timeout_cfg), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int grant(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (((v >> ((last + k) % 4)) & 4'd1) != 4'd0) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_req = 0; m_data = 0; m_src = 0; m_last = 3;
    m_wc = 0; m_fired = 0; m_err = 0;
    for (int i = 0; i < 8; i++) hist[i] = 1'b0;
  endtask

  // modes: 0 INIT, 1 IDLE, 2 WAIT; m_wc counts completed WAIT cycles of this transfer
  task automatic cyc();
    int g;
    logic [3:0] er;
    if (am >= 0) ack_sync = hist[am];
    else if (am == -2) ack_sync = 1'($urandom);
    @(negedge clk);
    g  = grant(req_valid, m_last);
    er = (!reset && m_mode == 1 && ack_sync == m_req && g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", req_ready, er);
    chk("busy", busy, reset || m_mode != 1);
    chk("cdc_req", cdc_req, m_req);
    chk("cdc_data", cdc_data, m_data);
    chk("cdc_src", cdc_src, 64'(m_src));
    chk("timeout_err", timeout_err, m_err);
    last_ready = req_ready;
    last_busy  = busy;
    last_err   = timeout_err;
    if (reset) model_reset();
    else begin
      m_err = 0;
      if (m_mode == 0) begin
        if (ack_sync == m_req) m_mode = 1;
      end else if (m_mode == 1) begin
        if (ack_sync != m_req) m_mode = 0;
        else if (g >= 0) begin
          m_req = !m_req; m_data = dat[g]; m_src = g; m_last = g;
          m_mode = 2; m_wc = 0; m_fired = 0;
        end
      end else begin
        if (ack_sync == m_req) m_mode = 1;
        else if (timeout_cfg != 0 && (m_wc < 255 ? m_wc : 255) == int'(timeout_cfg) - 1 && !m_fired) begin
          m_err = 1; m_fired = 1;
        end
        m_wc++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = m_req;
  endtask

  initial begin
    int nb, np, at, npulse, nr;
    logic [3:0] gq [$];
    logic bz [16];
    logic [3:0] exp_g [5];
    exp_g = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1};
    reset = 1; req_valid = 0; ack_sync = 0; timeout_cfg = 0; am = -1;
    for (int i = 0; i < 4; i++) dat[i] = 32'h1111_1111 * (i + 1);
    @(posedge clk);
    #1;
    model_reset();
    cyc();
    reset = 0;
    // round-robin order from reset with immediate ack loopback
    req_valid = 4'hF; am = 0;
    repeat (10) begin
      cyc();
      if (last_ready != 0) gq.push_back(last_ready);
    end
    chk("grant_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk($sformatf("grant_order%0d", i), gq[i], exp_g[i]);
    // single requester 2, ack three cycles late
    req_valid = 0;
    repeat (4) cyc();
    am = 3; dat[2] = 32'hDEADBEEF; req_valid = 4'b0100; nb = 0; np = 0;
    cyc();
    np += int'(last_ready[2]);
    req_valid = 0;
    repeat (8) begin
      cyc();
      nb += int'(last_busy);
      np += int'(last_ready[2]);
    end
    chk("r2_busy_cycles", nb, 4);
    chk("r2_ready_pulses", np, 1);
    chk("r2_data", cdc_data, 32'hDEADBEEF);
    chk("r2_src", cdc_src, 2);
    // timeout 5 with ack withheld
    am = 0;
    repeat (3) cyc();
    timeout_cfg = 5; am = -1; req_valid = 4'b0001; npulse = 0; at = -1;
    cyc();
    req_valid = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (last_err) begin npulse++; at = k; end
    end
    chk("to5_pulses", npulse, 1);
    chk("to5_cycle", at, 6);
    am = 0;
    repeat (3) cyc();
    chk("to5_recover", last_busy, 0);
    // timeout disabled, long wait past counter saturation
    timeout_cfg = 0; am = -1; req_valid = 4'b0010; npulse = 0;
    cyc();
    req_valid = 0;
    repeat (300) begin
      cyc();
      npulse += int'(last_err);
    end
    chk("to0_pulses", npulse, 0);
    chk("to0_still_busy", last_busy, 1);
    am = 0;
    repeat (3) cyc();
    // ack and timeout on the same cycle
    timeout_cfg = 3; am = 2; req_valid = 4'b1000; npulse = 0;
    cyc();
    req_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      bz[k] = last_busy;
      npulse += int'(last_err);
    end
    chk("tie_pulses", npulse, 0);
    chk("tie_busy_c3", bz[3], 1);
    chk("tie_busy_c4", bz[4], 0);
    // reset mid-WAIT with ack high
    timeout_cfg = 0; am = -1; req_valid = 4'b0001;
    cyc();
    req_valid = 0;
    cyc();
    reset = 1; ack_sync = 1;
    cyc();
    reset = 0; req_valid = 4'hF; nr = 0;
    repeat (3) begin
      cyc();
      nr += int'(last_ready != 0);
    end
    chk("rst_wait_no_ready", nr, 0);
    ack_sync = 0;
    cyc();
    cyc();
    chk("rst_first_grant", last_ready, 4'b0001);
    // randomized traffic
    for (int b = 0; b < 60; b++) begin
      am = $urandom_range(0, 5) - 2;
      timeout_cfg = 8'($urandom_range(0, 7));
      repeat (50) begin
        req_valid = 4'($urandom);
        for (int i = 0; i < 4; i++) dat[i] = $urandom;
        reset = ($urandom_range(0, 199) == 0);
        cyc();
      end
      reset = 0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/oh_cdc_txarb.md
OH_CDC_TXARB -- requirements
Module: oh_cdc_txarb

Interface
REQ-001 Parameter N, default 4: number of requesters (2..16).
REQ-002 Parameter DW, default 32: data width per requester.
REQ-003 Parameter TW, default 8: timeout counter width.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N  per-requester transfer request.
REQ-007 req_data  input  N*DW  requester i data at bits [i*DW +: DW].
REQ-008 req_ready  output  N  one-hot accept strobe; transfer i accepted when req_valid[i] & req_ready[i].
REQ-009 cdc_req  output  1  toggle-level request to far domain, registered.
REQ-010 cdc_data  output  DW  captured data, registered, stable while a transfer is outstanding.
REQ-011 cdc_src  output  $clog2(N)  index of requester owning cdc_data.
REQ-012 ack_sync  input  1  far-domain ack toggle, already passed through an external dsync stage in clk domain.
REQ-013 timeout_cfg  input  TW  WAIT cycle limit; 0 disables timeout.
REQ-014 busy  output  1  high when state != IDLE.
REQ-015 timeout_err  output  1  single-cycle pulse on timeout.

Function
REQ-016 FSM states: INIT, IDLE, WAIT.
REQ-017 INIT: req_ready=0; go to IDLE on the first cycle ack_sync==cdc_req.
REQ-018 IDLE: if any req_valid, assert req_ready for exactly one winner combinationally in same cycle; else req_ready=0.
REQ-019 Arbitration round-robin: search starts at index (last_grant+1) mod N, ascending with wrap.
REQ-020 On accept: next cycle cdc_data=req_data[winner], cdc_src=winner, cdc_req inverted, last_grant=winner, state=WAIT.
REQ-021 WAIT: req_ready=0; cdc_req, cdc_data, cdc_src held constant.
REQ-022 WAIT exit: ack_sync==cdc_req -> IDLE next cycle; earliest next accept is that IDLE cycle.
REQ-023 Minimum transfer period 2 cycles (accept, ack-match, accept).
REQ-024 Timeout counter cleared on WAIT entry, increments each WAIT cycle, saturates at all-ones.
REQ-025 timeout_cfg!=0 and counter reaching timeout_cfg-1 in WAIT -> timeout_err=1 next cycle, once per transfer; FSM stays in WAIT (toggle cannot be retracted).
REQ-026 Ack match and timeout in the same cycle: ack wins, no timeout_err.
REQ-027 timeout_cfg changed mid-WAIT: new value used from the following compare.
REQ-028 req_valid deassertion while not granted: no effect; no request queuing inside the block.
REQ-029 ack_sync toggling while in IDLE (spurious): ignored; state moves to INIT instead of accepting if ack_sync!=cdc_req.

Reset
REQ-030 reset=1 at a clock edge: state=INIT, cdc_req=0, cdc_data=0, cdc_src=0, last_grant=N-1, counter=0, timeout_err=0.
REQ-031 During reset, req_ready=0 and busy=1.
REQ-032 Reset mid-WAIT abandons the transfer; INIT blocks new accepts until ack_sync returns to 0.
REQ-033 After reset, requester 0 has highest priority.

Verification
REQ-034 Reset, ack_sync=0, req_valid=4'b1111 -> INIT 1 cycle, then grants 0,1,2,3,0 in order, each with cdc_req toggling 0->1->0->1->0.
REQ-035 Single requester 2 with data 0xDEADBEEF, ack looped back after 3 cycles -> cdc_data=0xDEADBEEF, cdc_src=2, busy high 4 cycles, req_ready[2] pulses once.
REQ-036 timeout_cfg=5, ack withheld -> timeout_err pulses exactly once, 5 cycles after the accept edge; later ack returns FSM to IDLE.
REQ-037 timeout_cfg=0, ack withheld 300 cycles -> no timeout_err, counter saturates, no wrap.
REQ-038 Reset asserted in WAIT with ack_sync=1 -> state INIT, req_ready=0 until ack_sync drops to 0, then normal accept.
REQ-039 Ack match and timeout coincide (timeout_cfg=3, ack after exactly 3 WAIT cycles) -> no timeout_err, IDLE next cycle.
